// File: rtl/aluout_pipe.sv
// ALU result pipeline: DEPTH stages of {valid, data, tag} with a forwarding lookup and an occupancy count.
// Latency: DEPTH cycles from accepted input to out_*, plus one cycle per stall cycle in between.
// Backpressure: stall freezes all state and drops the input; flush squashes every valid bit and wins over stall.
// Optional: define ALUOUT_ZFLAG_EN to carry a per-stage zero flag and expose out_zero.
module aluout_pipe #(
    parameter int W     = 32,
    parameter int DEPTH = 2,   // legal range 1..8
    parameter int TW    = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic [TW-1:0] in_tag,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    output logic [TW-1:0] out_tag,
    input  logic [TW-1:0] fwd_tag,
    output logic          fwd_hit,
    output logic [W-1:0]  fwd_data,
    output logic [3:0]    occupancy
`ifdef ALUOUT_ZFLAG_EN
    ,
    output logic          out_zero
`endif
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     data_q [DEPTH];
    logic [TW-1:0]    tag_q  [DEPTH];

    // The pipe only moves when nothing is holding or squashing it.
    logic shift;
    assign shift = !flush && !stall;

    // Valid bits and occupancy: flush clears both, stall holds, shift advances.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q     <= '0;
            occupancy <= '0;
        end else if (flush) begin
            vld_q     <= '0;
            occupancy <= '0;
        end else if (!stall) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                vld_q[i] <= vld_q[i-1];
            end
            vld_q[0]  <= in_valid;
            // Incremental count: one in at the head, one out at the tail.
            occupancy <= occupancy + {3'b000, in_valid} - {3'b000, vld_q[DEPTH-1]};
        end
    end

    // Data and tag payload: untouched by flush, head loads only on a valid input.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (shift) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                data_q[i] <= data_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
            if (in_valid) begin
                data_q[0] <= in_data;
                tag_q[0]  <= in_tag;
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];

    // Forwarding search from oldest to youngest so the youngest match overwrites; tag 0 never hits.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld_q[i] && (tag_q[i] == fwd_tag) && (fwd_tag != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[i];
            end
        end
    end

`ifdef ALUOUT_ZFLAG_EN
    logic [DEPTH-1:0] zero_q;

    // Zero flag travels with the data word so it stays aligned under stall and flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zero_q <= '0;
        end else if (shift) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                zero_q[i] <= zero_q[i-1];
            end
            if (in_valid) begin
                zero_q[0] <= (in_data == '0);
            end
        end
    end

    assign out_zero = zero_q[DEPTH-1] & vld_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_aluout_pipe.sv
// Bench for aluout_pipe (DEPTH=3): directed scenarios plus random traffic against a transaction-level model.
// Model tracks each accepted result by its age in the pipe; a scoreboard queue holds expected outputs in order.
// A negedge monitor compares out_*, occupancy and forwarding against the model independently of the driver.
module tb_aluout_pipe;
    localparam int W     = 32;
    localparam int DEPTH = 3;
    localparam int TW    = 5;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic [TW-1:0] in_tag;
    logic          stall;
    logic          flush;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic [TW-1:0] fwd_tag;
    logic          fwd_hit;
    logic [W-1:0]  fwd_data;
    logic [3:0]    occupancy;
`ifdef ALUOUT_ZFLAG_EN
    logic          out_zero;
`endif

    always #5 clock = ~clock;

    aluout_pipe #(.W(W), .DEPTH(DEPTH), .TW(TW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .fwd_tag   (fwd_tag),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .occupancy (occupancy)
`ifdef ALUOUT_ZFLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit mon_en   = 1'b0;

    // In-flight transaction: age counts pipe advances since acceptance (0 = just entered).
    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        int            age;
    } ent_t;
    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
    } exp_t;

    ent_t inflight[$];   // index 0 = youngest
    exp_t exp_q[$];      // expected outputs, oldest first

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tot_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic bit m_out_valid();
        return (inflight.size() > 0) && (inflight[inflight.size()-1].age == DEPTH - 1);
    endfunction

    // Youngest in-flight result with a matching nonzero tag.
    task automatic m_fwd(input logic [TW-1:0] t, output logic hit, output logic [W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (t != '0) begin
            for (int i = 0; i < inflight.size(); i++) begin
                if (inflight[i].tag == t) begin
                    hit = 1'b1;
                    d   = inflight[i].data;
                    break;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, return 1 time unit after it.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic [TW-1:0] t,
                        input logic st, input logic fl);
        ent_t e;
        exp_t x;
        in_valid = iv;
        in_data  = d;
        in_tag   = t;
        stall    = st;
        flush    = fl;
        @(posedge clock);
        if (fl) begin
            inflight.delete();
            exp_q.delete();
        end else if (!st) begin
            foreach (inflight[i]) inflight[i].age++;
            while (inflight.size() > 0 && inflight[inflight.size()-1].age >= DEPTH)
                void'(inflight.pop_back());
            if (iv) begin
                e.data = d; e.tag = t; e.age = 0;
                inflight.push_front(e);
                x.data = d; x.tag = t;
                exp_q.push_back(x);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compares everything visible against the model; pops when the tail will leave.
    always @(negedge clock) begin
        logic          h;
        logic [W-1:0]  d;
        if (reset_n && mon_en) begin
            check("mon_out_valid", {31'b0, out_valid}, {31'b0, m_out_valid()});
            check("mon_occupancy", {28'b0, occupancy}, inflight.size());
            m_fwd(fwd_tag, h, d);
            check("mon_fwd_hit", {31'b0, fwd_hit}, {31'b0, h});
            check("mon_fwd_data", fwd_data, d);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL mon_unexpected_out: got data 0x%0h tag %0d, required no output", out_data, out_tag);
                end else begin
                    check("mon_out_data", out_data, exp_q[0].data);
                    check("mon_out_tag", {27'b0, out_tag}, {27'b0, exp_q[0].tag});
`ifdef ALUOUT_ZFLAG_EN
                    check("mon_out_zero", {31'b0, out_zero}, {31'b0, exp_q[0].data == '0});
`endif
                    if (!stall && !flush) void'(exp_q.pop_front());
                end
            end
`ifdef ALUOUT_ZFLAG_EN
            else check("mon_out_zero_idle", {31'b0, out_zero}, '0);
`endif
        end
    end

    int exp_occ[6] = '{1, 2, 3, 2, 1, 0};

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_tag   = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        fwd_tag  = '0;
        #1;
        check("reset_out_valid", {31'b0, out_valid}, '0);
        check("reset_out_data", out_data, '0);
        check("reset_occupancy", {28'b0, occupancy}, '0);
        #2 reset_n = 1'b1;
        mon_en = 1'b1;

        // Latency: three back-to-back results emerge after edges 3, 4, 5.
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step(1'b1, 32'h11 * (i + 1), TW'(i + 1), 1'b0, 1'b0);
            else       step(1'b0, '0, '0, 1'b0, 1'b0);
            check($sformatf("lat_occ_%0d", i), {28'b0, occupancy}, exp_occ[i]);
            if (i < 2) check($sformatf("lat_nvalid_%0d", i), {31'b0, out_valid}, '0);
            else if (i < 5) begin
                check($sformatf("lat_valid_%0d", i), {31'b0, out_valid}, 1);
                check($sformatf("lat_data_%0d", i), out_data, 32'h11 * (i - 1));
            end
        end

        // Stall: 0xAA in stage 1, two stall cycles with 0xBB offered and dropped.
        step(1'b1, 32'hAA, 5'd9, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 32'hBB, 5'd10, 1'b1, 1'b0);
        check("stall_occ_a", {28'b0, occupancy}, 1);
        step(1'b1, 32'hBB, 5'd10, 1'b1, 1'b0);
        check("stall_occ_b", {28'b0, occupancy}, 1);
        check("stall_not_yet", {31'b0, out_valid}, '0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("stall_late_valid", {31'b0, out_valid}, 1);
        check("stall_late_data", out_data, 32'hAA);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("stall_bb_dropped", {31'b0, out_valid}, '0);
        check("stall_empty", {28'b0, occupancy}, '0);

        // Flush beats stall and in_valid with three entries in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h61 + i, TW'(i + 11), 1'b0, 1'b0);
        step(1'b1, 32'h55, 5'd5, 1'b1, 1'b1);
        check("flush_valid", {31'b0, out_valid}, '0);
        check("flush_occ", {28'b0, occupancy}, '0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0);
            check($sformatf("flush_no55_%0d", i), {31'b0, out_valid}, '0);
        end

        // Forwarding: duplicate tag 7, youngest wins; tag 0 never hits.
        step(1'b1, 32'h100, 5'd7, 1'b0, 1'b0);
        step(1'b1, 32'h123, 5'd4, 1'b0, 1'b0);
        step(1'b1, 32'h200, 5'd7, 1'b0, 1'b0);
        fwd_tag = 5'd7; #1;
        check("fwd7_hit", {31'b0, fwd_hit}, 1);
        check("fwd7_data", fwd_data, 32'h200);
        fwd_tag = 5'd4; #1;
        check("fwd4_data", fwd_data, 32'h123);
        fwd_tag = 5'd9; #1;
        check("fwd9_miss", {31'b0, fwd_hit}, '0);
        step(1'b1, 32'h77, 5'd0, 1'b0, 1'b0);
        fwd_tag = 5'd0; #1;
        check("fwd0_hit", {31'b0, fwd_hit}, '0);
        check("fwd0_data", fwd_data, '0);

        // Mid-operation asynchronous reset with a full pipe, between edges.
        reset_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, out_valid}, '0);
        check("arst_data", out_data, '0);
        check("arst_occ", {28'b0, occupancy}, '0);
        inflight.delete();
        exp_q.delete();
        #1 reset_n = 1'b1;
        fwd_tag = '0;

`ifdef ALUOUT_ZFLAG_EN
        step(1'b1, 32'h0, 5'd2, 1'b0, 1'b0);
        step(1'b1, 32'h5, 5'd3, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("zf_one", {31'b0, out_zero}, 1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("zf_zero", {31'b0, out_zero}, '0);
        check("zf_valid", {31'b0, out_valid}, 1);
        for (int i = 0; i < 3; i++) step(1'b1, '0, 5'd6, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("zf_flush", {31'b0, out_zero}, '0);
`endif

        // Random traffic with small tag range to create duplicates.
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] d;
            d = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            fwd_tag = TW'($urandom_range(0, 7));
            step($urandom_range(0, 2) != 0, d, TW'($urandom_range(0, 7)),
                 $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0);
        end
        idle(DEPTH + 1);
        check("final_drained", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
